// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction fetch unit. Holds the PC, issues one
//                instruction-memory read at a time, hands the instruction and
//                its PC to decode over valid/ready, and drops stale fetches
//                when a branch/jump redirect arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(64'h0000_0000_8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // instruction memory request channel
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    // instruction memory response channel
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    // decode-stage handshake
    output logic                  ifu2idu_valid,
    input  logic                  idu2ifu_ready,
    output logic [INST_WIDTH-1:0] ifu2idu_inst,
    output logic [ADDR_WIDTH-1:0] ifu2idu_pc,
    output logic                  ifu2idu_fault,
    // branch/jump redirect
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    // Instruction presented to decode while nothing valid has been fetched.
    localparam logic [INST_WIDTH-1:0] NOP_INST      = INST_WIDTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP       = ADDR_WIDTH'(4);
    // Redirect targets are forced onto a 4-byte boundary.
    localparam logic [ADDR_WIDTH-1:0] PC_ALIGN_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // presenting a fetch request
        S_WAIT = 2'd1,  // request accepted, waiting for the response
        S_HOLD = 2'd2   // instruction held for decode
    } state_t;

    state_t                  state_q,  state_d;
    logic [ADDR_WIDTH-1:0]   pc_q,     pc_d;
    logic                    drop_q,   drop_d;
    logic [INST_WIDTH-1:0]   inst_q,   inst_d;
    logic [ADDR_WIDTH-1:0]   out_pc_q, out_pc_d;
    logic                    fault_q,  fault_d;

    logic                    req_fire;
    logic                    idu_fire;

    // Request and decode-valid are suppressed in any redirect cycle so that
    // neither handshake can complete against a stale PC. The request is also
    // held low while reset is asserted, since the reset state is S_REQ.
    assign imem_req_valid = rst_n && (state_q == S_REQ) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign ifu2idu_valid  = (state_q == S_HOLD) && !redirect_valid;
    assign ifu2idu_inst   = inst_q;
    assign ifu2idu_pc     = out_pc_q;
    assign ifu2idu_fault  = fault_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign idu_fire = ifu2idu_valid && idu2ifu_ready;

    // Next-state logic: fetch sequencing with redirect taking priority.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        inst_d   = inst_q;
        out_pc_d = out_pc_q;
        fault_d  = fault_q;

        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q || redirect_valid) begin
                        // Stale response: the PC it belongs to is no longer wanted.
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        inst_d   = imem_resp_data;
                        out_pc_d = pc_q;
                        fault_d  = imem_resp_err;
                        state_d  = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Response still outstanding; remember to throw it away.
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (idu_fire) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc & PC_ALIGN_MASK;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            inst_q   <= NOP_INST;
            out_pc_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            inst_q   <= inst_d;
            out_pc_q <= out_pc_d;
            fault_q  <= fault_d;
        end
    end

endmodule
`default_nettype wire
